// File: rtl/array_div_server.sv
// array_div_server: 6-lane fixed-point divider sharing one control FSM (radix-2 restoring).
// Latency: done pulses WIDTH+FRAC_BITS+2 enabled cycles after the accepting edge (2 when divisor is 0).
// Backpressure: a start while busy or during the done cycle is dropped, not queued; en=0 freezes everything.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   en            clock enable; low holds all state and outputs
//   start         request strobe, accepted only when idle and not in the done cycle
//   dividends     LANES signed fixed-point dividends, captured on accept
//   divisor       common signed fixed-point divisor, captured on accept
//   quotients     LANES results, valid from done and held until the next result
//   busy          high from the cycle after accept until done
//   done          one-cycle result strobe (stretched while en=0)
//   div_by_zero   divisor was zero (updated with done)
//   overflow      per-lane saturation flags (updated with done)
module array_div_server #(
  parameter int WIDTH     = 36,
  parameter int FRAC_BITS = 18,
  parameter int LANES     = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         start,
  input  logic [LANES-1:0][WIDTH-1:0]  dividends,
  input  logic [WIDTH-1:0]             divisor,
  output logic [LANES-1:0][WIDTH-1:0]  quotients,
  output logic                         busy,
  output logic                         done,
  output logic                         div_by_zero,
  output logic [LANES-1:0]             overflow
);

  localparam int NW = WIDTH + FRAC_BITS;   // numerator / raw quotient width
  localparam int CW = $clog2(NW);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX_MAG = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [CW-1:0]    CNT_TOP = CW'(NW - 1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_SIGN
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]                 cnt;
  logic [LANES-1:0][WIDTH-1:0]   mag_a;    // dividend magnitudes
  logic [WIDTH-1:0]              mag_b;    // divisor magnitude
  logic                          b_zero;
  logic [LANES-1:0]              neg;      // result sign per lane
  // Numerator bits shift out of the top while quotient bits shift in at the
  // bottom, so after the last iteration this register holds the raw quotient.
  // On the divide-by-zero path it still holds |dividend| << FRAC_BITS.
  logic [LANES-1:0][NW-1:0]      num;
  logic [LANES-1:0][WIDTH-1:0]   rem;

  logic                          accept;

  // Per-lane iteration step
  logic [LANES-1:0][WIDTH:0]     rem_sh;
  logic [LANES-1:0]              ge;
  logic [LANES-1:0][WIDTH-1:0]   rem_sub;

  // Per-lane sign/saturation stage
  logic [LANES-1:0]              sat;
  logic [LANES-1:0][WIDTH-1:0]   res_mag;
  logic [LANES-1:0][WIDTH-1:0]   res;

  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] x);
    // The most negative word maps to 2^(WIDTH-1), still representable unsigned.
    return x[WIDTH-1] ? (~x + ONE) : x;
  endfunction

  // The done cycle is excluded so a requester cannot chain back-to-back
  // without seeing its result first.
  assign accept = en & start & (state == S_IDLE) & ~done;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LOAD;
      S_LOAD: state_nxt = b_zero ? S_SIGN : S_ITER;
      S_ITER: if (cnt == '0) state_nxt = S_SIGN;
      S_SIGN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- Lane datapath (combinational) ----------------
  always_comb begin
    rem_sh  = '0;
    ge      = '0;
    rem_sub = '0;
    sat     = '0;
    res_mag = '0;
    res     = '0;
    for (int i = 0; i < LANES; i++) begin
      rem_sh[i]  = {rem[i], num[i][NW-1]};
      ge[i]      = (rem_sh[i] >= {1'b0, mag_b});
      // When ge is set the true difference is below mag_b, so the low
      // WIDTH bits of the modular subtraction are the exact remainder.
      rem_sub[i] = rem_sh[i][WIDTH-1:0] - mag_b;

      if (b_zero) begin
        sat[i] = (num[i] != '0);
      end else begin
        sat[i] = |num[i][NW-1:WIDTH-1];
      end
      res_mag[i] = sat[i] ? MAX_MAG : num[i][WIDTH-1:0];
      res[i]     = neg[i] ? (~res_mag[i] + ONE) : res_mag[i];
    end
  end

  // ---------------- Registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      b_zero      <= 1'b0;
      neg         <= '0;
      num         <= '0;
      rem         <= '0;
      quotients   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= '0;
    end else if (en) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            busy   <= 1'b1;
            mag_b  <= mag_of(divisor);
            b_zero <= (divisor == '0);
            for (int i = 0; i < LANES; i++) begin
              mag_a[i] <= mag_of(dividends[i]);
              neg[i]   <= dividends[i][WIDTH-1] ^ divisor[WIDTH-1];
            end
          end
        end
        S_LOAD: begin
          cnt <= CNT_TOP;
          for (int i = 0; i < LANES; i++) begin
            num[i] <= {mag_a[i], {FRAC_BITS{1'b0}}};
            rem[i] <= '0;
          end
        end
        S_ITER: begin
          cnt <= cnt - CNT_ONE;
          for (int i = 0; i < LANES; i++) begin
            num[i] <= {num[i][NW-2:0], ge[i]};
            rem[i] <= ge[i] ? rem_sub[i] : rem_sh[i][WIDTH-1:0];
          end
        end
        S_SIGN: begin
          quotients   <= res;
          overflow    <= sat;
          div_by_zero <= b_zero;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
